// File: rtl/fp9_to_fp8_pack_core.sv
// rtl/fp9_to_fp8_pack_core.sv - FP9E5M3 beat converter/packer onto a 32-bit bus (FP16, FP8 E4M3/E5M2, FP4 E2M1)
module fp9_to_fp8_pack_core #(
  parameter int         NUM_ELEM    = 4,
  parameter logic [4:0] TYPE_FP4    = 5'd1,
  parameter logic [4:0] TYPE_FP8    = 5'd2,
  parameter logic [4:0] TYPE_FP16   = 5'd3,
  parameter logic [2:0] SUB_FP8E5M2 = 3'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            type_cd,
  input  logic [2:0]            type_cd_sub,
  input  logic [9*NUM_ELEM-1:0] in,
  input  logic                  in_last_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [8*NUM_ELEM-1:0] out,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  localparam int OW = 8 * NUM_ELEM;

  typedef enum logic [1:0] {S_EMPTY, S_HALF, S_FULL, S_FULL_HI} state_t;
  typedef enum logic [1:0] {MODE_E4M3, MODE_E5M2, MODE_FP4, MODE_FP16} mode_t;

  state_t          state;
  mode_t           live_mode, lat_mode, cur_mode;
  logic [OW-1:0]   hi;
  logic [OW-1:0]   w8;
  logic [OW/2-1:0] w4;
  logic [2*OW-1:0] w16;
  logic            accept;

  function automatic logic [7:0] to_e4m3(input logic [8:0] x);
    logic       s;
    logic [4:0] e;
    logic [2:0] m;
    logic [7:0] r;
    {s, e, m} = x;
    if (e == 5'h1F)                               r = {s, (m == 3'd0) ? 7'h7E : 7'h7F};
    else if (e < 5'd9)                            r = {s, 7'h00};
    else if (e > 5'd23 || (e == 5'd23 && m == 3'b111)) r = {s, 7'h7E};
    else                                          r = {s, e[3:0] + 4'd8, m};
    return r;
  endfunction

  // Exp carry from mantissa rounding falls out of the 7-bit add; exp 30 overflows to Inf.
  function automatic logic [7:0] to_e5m2(input logic [8:0] x);
    logic       s;
    logic [4:0] e;
    logic [2:0] m;
    logic [6:0] sum;
    logic [7:0] r;
    {s, e, m} = x;
    sum = {e, m[2:1]} + {6'd0, m[1] & m[0]};
    if (e == 5'h1F) r = {s, (m == 3'd0) ? 7'h7C : 7'h7E};
    else            r = {s, sum};
    return r;
  endfunction

  // Thresholds per binade, ties resolved toward the even E2M1 code.
  function automatic logic [3:0] to_e2m1(input logic [8:0] x);
    logic       s;
    logic [4:0] e;
    logic [2:0] m;
    logic [2:0] c;
    {s, e, m} = x;
    case (e)
      5'd0:    c = 3'b000;
      5'd13:   c = (m == 3'd0) ? 3'b000 : 3'b001;
      5'd14:   c = (m <= 3'd3) ? 3'b001 : 3'b010;
      5'd15:   c = (m <= 3'd2) ? 3'b010 : (m <= 3'd5) ? 3'b011 : 3'b100;
      5'd16:   c = (m <= 3'd2) ? 3'b100 : (m <= 3'd5) ? 3'b101 : 3'b110;
      5'd17:   c = (m <= 3'd2) ? 3'b110 : 3'b111;
      default: c = (e >= 5'd18) ? 3'b111 : 3'b000;
    endcase
    return {s, c};
  endfunction

  always_comb begin
    live_mode = MODE_E4M3;
    if (type_cd == TYPE_FP4)       live_mode = MODE_FP4;
    else if (type_cd == TYPE_FP16) live_mode = MODE_FP16;
    else if (type_cd == TYPE_FP8 && type_cd_sub == SUB_FP8E5M2) live_mode = MODE_E5M2;
  end

  assign cur_mode = (state == S_HALF) ? lat_mode : live_mode;

  always_comb begin
    w8  = '0;
    w4  = '0;
    w16 = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      w8[8*i+:8]   = (cur_mode == MODE_E5M2) ? to_e5m2(in[9*i+:9]) : to_e4m3(in[9*i+:9]);
      w4[4*i+:4]   = to_e2m1(in[9*i+:9]);
      w16[16*i+:16] = {in[9*i+:9], 7'b0};
    end
  end

  always_comb begin
    case (state)
      S_EMPTY, S_HALF: in_ready_o = 1'b1;
      S_FULL:          in_ready_o = out_ready_i;
      default:         in_ready_o = 1'b0;
    endcase
  end

  assign accept = in_valid_i && in_ready_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_EMPTY;
      out         <= '0;
      out_valid_o <= 1'b0;
      hi          <= '0;
      lat_mode    <= MODE_E4M3;
    end else begin
      case (state)
        S_EMPTY, S_FULL: begin
          if (accept) begin
            lat_mode <= live_mode;
            case (live_mode)
              MODE_FP4: begin
                out         <= {{(OW/2){1'b0}}, w4};
                state       <= in_last_i ? S_FULL : S_HALF;
                out_valid_o <= in_last_i;
              end
              MODE_FP16: begin
                out         <= w16[OW-1:0];
                hi          <= w16[2*OW-1:OW];
                state       <= S_FULL_HI;
                out_valid_o <= 1'b1;
              end
              default: begin
                out         <= w8;
                state       <= S_FULL;
                out_valid_o <= 1'b1;
              end
            endcase
          end else if (state == S_FULL && out_ready_i) begin
            state       <= S_EMPTY;
            out_valid_o <= 1'b0;
          end
        end
        S_HALF: begin
          if (in_valid_i) begin
            out[OW-1:OW/2] <= w4;
            state          <= S_FULL;
            out_valid_o    <= 1'b1;
          end
        end
        S_FULL_HI: begin
          if (out_ready_i) begin
            out   <= hi;
            state <= S_FULL;
          end
        end
        default: begin
          state       <= S_EMPTY;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp9_to_fp8_pack_core.sv
// tb/tb_fp9_to_fp8_pack_core.sv - self-checking bench for fp9_to_fp8_pack_core
module tb_fp9_to_fp8_pack_core;

  localparam logic [4:0] T_FP4  = 5'd1;
  localparam logic [4:0] T_FP8  = 5'd2;
  localparam logic [4:0] T_FP16 = 5'd3;
  localparam logic [2:0] S_E4   = 3'd0;
  localparam logic [2:0] S_E5   = 3'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  type_cd = T_FP8;
  logic [2:0]  type_cd_sub = S_E4;
  logic [35:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int total = 0;
  int bad = 0;

  fp9_to_fp8_pack_core dut (
    .clk(clk), .rst_n(rst_n), .type_cd(type_cd), .type_cd_sub(type_cd_sub),
    .in(in_data), .in_last_i(in_last), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out(out_word), .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [4:0]  tc;
    logic [2:0]  sub;
    logic [35:0] data;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
  } vec_t;

  function automatic logic [35:0] pk(input logic [8:0] e3, input logic [8:0] e2,
                                     input logic [8:0] e1, input logic [8:0] e0);
    return {e3, e2, e1, e0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] tc, input logic [2:0] sub, input logic [35:0] d,
                      input logic last);
    int n = 0;
    type_cd = tc; type_cd_sub = sub; in_data = d; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pop(input string name, input logic [31:0] exp);
    int n = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check(name, out_word, exp);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [8:0] sb_elem(input int k, input int i);
    return {1'(i % 2), 5'(9 + ((k + i) % 15)), 3'((k + 2 * i) % 7)};
  endfunction

  function automatic logic [7:0] sb_byte(input int k, input int i);
    return {1'(i % 2), 4'(1 + ((k + i) % 15)), 3'((k + 2 * i) % 7)};
  endfunction

  vec_t        vecs[7];
  logic [31:0] q[$];

  initial begin
    vecs[0] = '{"e4m3_basic", T_FP8, S_E4, pk(9'h040, 9'h0BF, 9'h178, 9'h078), 32'h007E_B838, 32'h0};
    vecs[1] = '{"e5m2_round", T_FP8, S_E5, pk(9'h075, 9'h077, 9'h07B, 9'h079), 32'h3A3C_3E3C, 32'h0};
    vecs[2] = '{"e4m3_edges", T_FP8, S_E4, pk(9'h14D, 9'h0C0, 9'h1F9, 9'h0F8), 32'h8D7E_FF7E, 32'h0};
    vecs[3] = '{"e5m2_edges", T_FP8, S_E5, pk(9'h103, 9'h0F7, 9'h1FC, 9'h0F8), 32'h827C_FE7C, 32'h0};
    vecs[4] = '{"other_type", 5'd0,  S_E4, pk(9'h040, 9'h0BF, 9'h178, 9'h078), 32'h007E_B838, 32'h0};
    vecs[5] = '{"fp8_badsub", T_FP8, 3'd7, pk(9'h040, 9'h0BF, 9'h178, 9'h078), 32'h007E_B838, 32'h0};
    vecs[6] = '{"fp16_mix",   T_FP16, S_E4, pk(9'h001, 9'h0F9, 9'h0F8, 9'h178), 32'h7C00_BC00, 32'h0080_7C80};

    // reset held with a pending beat: nothing accepted, outputs cleared
    in_valid = 1'b1; in_data = vecs[0].data;
    repeat (3) begin
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_out", out_word, 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("rst_no_accept", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      push(vecs[v].tc, vecs[v].sub, vecs[v].data, 1'b0);
      pop(vecs[v].name, vecs[v].exp_lo);
      if (vecs[v].tc == T_FP16) pop({vecs[v].name, "_hi"}, vecs[v].exp_hi);
    end

    // FP8 streaming at full rate
    type_cd = T_FP8; type_cd_sub = S_E4; in_data = vecs[0].data;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    repeat (5) begin
      @(negedge clk);
      check("stream_out", out_word, 32'h007E_B838);
      check("stream_flow", {30'd0, out_valid, in_ready}, 32'd3);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // FP4 pair; live type changes while HALF must be ignored
    push(T_FP4, S_E4, pk(9'h168, 9'h08D, 9'h07C, 9'h078), 1'b0);
    @(negedge clk);
    check("fp4_half_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    push(T_FP8, S_E5, pk(9'h070, 9'h070, 9'h070, 9'h070), 1'b0);
    pop("fp4_pair", 32'h1111_8732);
    push(T_FP4, S_E4, pk(9'h070, 9'h070, 9'h070, 9'h078), 1'b1);
    pop("fp4_last", 32'h0000_1112);
    push(T_FP4, S_E4, pk(9'h074, 9'h07E, 9'h082, 9'h08A), 1'b1);
    pop("fp4_ties", 32'h0000_2446);

    // FP16 split under back-pressure
    push(T_FP16, S_E4, pk(9'h078, 9'h078, 9'h078, 9'h078), 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("bp_out", out_word, 32'h3C00_3C00);
      check("bp_flow", {30'd0, out_valid, in_ready}, 32'd2);
    end
    @(posedge clk); #1;
    pop("fp16_w0", 32'h3C00_3C00);
    pop("fp16_w1", 32'h3C00_3C00);
    @(negedge clk);
    check("fp16_drained", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // accept of an FP4 first beat while consuming an FP8 word
    push(T_FP8, S_E4, vecs[0].data, 1'b0);
    type_cd = T_FP4; in_data = pk(9'h078, 9'h078, 9'h078, 9'h078); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("simul_out", out_word, 32'h007E_B838);
    check("simul_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("simul_gap", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    push(T_FP4, S_E4, pk(9'h070, 9'h070, 9'h070, 9'h070), 1'b0);
    pop("simul_fp4", 32'h1111_2222);

    // FP8 scoreboard with toggling out_ready
    begin
      int k = 0;
      int cyc = 0;
      logic acc;
      type_cd = T_FP8; type_cd_sub = S_E4;
      while (k < 40 && cyc < 400) begin
        for (int i = 0; i < 4; i++) in_data[9*i+:9] = sb_elem(k, i);
        out_ready = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (q.size() == 0) check("sb_extra", out_word, 32'hxxxx_xxxx);
          else check("sb_word", out_word, q.pop_front());
        end
        acc = in_ready;
        if (acc) q.push_back({sb_byte(k, 3), sb_byte(k, 2), sb_byte(k, 1), sb_byte(k, 0)});
        @(posedge clk); #1;
        if (acc) k++;
        cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (out_valid) begin
          if (q.size() == 0) check("sb_extra", out_word, 32'hxxxx_xxxx);
          else check("sb_word", out_word, q.pop_front());
        end
        @(posedge clk); #1;
      end
      check("sb_beats", 32'(k), 32'd40);
      check("sb_left", 32'(q.size()), 32'd0);
      out_ready = 1'b0;
    end

    // reset while the FP16 high word is pending
    push(T_FP16, S_E4, vecs[6].data, 1'b0);
    @(negedge clk);
    check("rst16_lo", out_word, 32'h7C00_BC00);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst16_valid", 32'(out_valid), 32'd0);
      check("rst16_out", out_word, 32'h0);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
